// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the two-requester request/response handshake and the ALU drive
//   bus of alu_share_arbiter.
//   slave  : arbiter view (receives requests, drives responses and ALU inputs)
//   master : environment view (requesters plus the combinational ALU)
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_op*/req_a*/req_b*      requester 0/1 op code and operands
//   rsp_valid/rsp_ready [1:0]  per-requester response handshake
//   rsp_result/rsp_zero        captured ALU result and zero flag (shared)
//   alu_a/alu_b/alu_op         registered ALU drive
//   alu_result/alu_zero        ALU outputs
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [OPW-1:0]   req_op0;
   logic [OPW-1:0]   req_op1;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b0;
   logic [WIDTH-1:0] req_b1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      input  rsp_ready, alu_result, alu_zero,
      output req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_op
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
      output rsp_ready, alu_result, alu_zero,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. One operation is in
//   flight at a time; requesters are served round-robin. Accepted operands are
//   registered onto the ALU inputs, the ALU result/zero flag is captured one
//   cycle later and returned to the winning requester over a valid/ready
//   response handshake.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : request/response handshake and ALU drive (slave modport)
//   busy   : high while an operation is executing or awaiting response accept
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_share_arbiter_if.slave  bus,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   logic             grant;
   logic [1:0]       req_ready_c;

   // Lone requester wins; on contention the priority pointer decides.
   always_comb begin
      unique case (bus.req_valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ptr_q;
         default: grant = 1'b0;
      endcase
   end

   // Ready only in IDLE and only for the granted requester; forced low while
   // reset is asserted so no handshake can be seen during reset.
   always_comb begin
      req_ready_c = '0;
      if (rst_n && (state_q == IDLE) && (bus.req_valid != 2'b00)) begin
         req_ready_c[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_valid_d  = rsp_valid_q;
      busy_d       = busy_q;
      unique case (state_q)
         IDLE: begin
            if ((bus.req_valid & req_ready_c) != 2'b00) begin
               owner_d  = grant;
               alu_a_d  = grant ? bus.req_a1  : bus.req_a0;
               alu_b_d  = grant ? bus.req_b1  : bus.req_b0;
               alu_op_d = grant ? bus.req_op1 : bus.req_op0;
               busy_d   = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d         = bus.alu_result;
            rsp_zero_d           = bus.alu_zero;
            rsp_valid_d          = '0;
            rsp_valid_d[owner_q] = 1'b1;
            state_d              = RESP;
         end
         RESP: begin
            // Only the owner's rsp_ready completes the response.
            if (bus.rsp_ready[owner_q]) begin
               rsp_valid_d = '0;
               ptr_d       = ~owner_q;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = '0;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         owner_q      <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_valid_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   logic clk;
   logic rst_n;
   logic busy;

   int n_pass   = 0;
   int n_checks = 0;

   alu_share_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

   alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: ops 0..7 per the op table, 8..15 an arbitrary distinct function.
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << b[4:0];
         4'd7:    return a >> b[4:0];
         default: return a ^ ~b;
      endcase
   endfunction

   always_comb begin
      bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
      bus.alu_zero   = (bus.alu_result == 32'd0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   logic        m_pend;
   logic        m_owner;
   logic        m_ptr;
   int          m_age;
   logic [31:0] m_a, m_b, m_res, m_exp_res;
   logic [3:0]  m_op;
   logic        m_zero, m_exp_zero;

   task model_reset();
      m_pend = 0; m_owner = 0; m_ptr = 0; m_age = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_zero = 0;
      m_exp_res = 0; m_exp_zero = 0;
   endtask

   always @(negedge clk) begin
      logic       g;
      logic [1:0] e_rr, e_rv;
      if (!rst_n) model_reset();
      g    = (bus.req_valid == 2'b11) ? m_ptr : bus.req_valid[1];
      e_rr = 2'b00;
      if (rst_n && !m_pend && bus.req_valid != 2'b00) e_rr = g ? 2'b10 : 2'b01;
      e_rv = (m_pend && m_age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready",  bus.req_ready,  e_rr);
      chk("rsp_valid",  bus.rsp_valid,  e_rv);
      chk("busy",       busy,           m_pend);
      chk("alu_a",      bus.alu_a,      m_a);
      chk("alu_b",      bus.alu_b,      m_b);
      chk("alu_op",     bus.alu_op,     m_op);
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_zero",   bus.rsp_zero,   m_zero);
      if (rst_n) begin
         if (!m_pend) begin
            if (bus.req_valid != 2'b00) begin
               m_pend  = 1;
               m_owner = g;
               m_age   = 0;
               m_a     = g ? bus.req_a1  : bus.req_a0;
               m_b     = g ? bus.req_b1  : bus.req_b0;
               m_op    = g ? bus.req_op1 : bus.req_op0;
               m_exp_res  = alu_f(m_op, m_a, m_b);
               m_exp_zero = (m_exp_res == 32'd0);
            end
         end else if (m_age == 0) begin
            m_age  = 1;
            m_res  = m_exp_res;
            m_zero = m_exp_zero;
         end else if (bus.rsp_ready[m_owner]) begin
            m_pend = 0;
            m_ptr  = ~m_owner;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      if (r == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
      else        begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_reached", busy, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
   endtask

   task automatic txn(input int r, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, output logic acc, output logic [31:0] res,
                      output logic z, output int lat, output logic [1:0] rv,
                      output logic [31:0] ra, output logic [31:0] rb);
      acc = 0; res = 0; z = 0; lat = 0; rv = 0; ra = 0; rb = 0;
      @(posedge clk); #1;
      set_req(r, op, a, b);
      bus.req_valid[r] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready[r]) begin acc = 1; break; end
      end
      @(posedge clk); #1;
      bus.req_valid[r] = 1'b0;
      set_req(r, 4'($urandom_range(0, 15)), $urandom, $urandom);
      if (!acc) return;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid[r]) break;
      end
      res = bus.rsp_result; z = bus.rsp_zero; rv = bus.rsp_valid;
      ra = bus.alu_a; rb = bus.alu_b;
      wait_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, z;
      logic [31:0] res, ra, rb;
      logic [1:0]  rv;
      int          lat;
      int          g_q[$];
      int          c_q[$];
      logic [31:0] r_q[$];

      rst_n = 0;
      bus.req_valid = 0;
      bus.rsp_ready = 2'b11;
      set_req(0, 0, 0, 0);
      set_req(1, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      #1;
      chk("rst_busy",      busy,           1'b0);
      chk("rst_alu_a",     bus.alu_a,      32'd0);
      chk("rst_rsp_valid", bus.rsp_valid,  2'b00);
      chk("rst_result",    bus.rsp_result, 32'd0);

      // ADD from requester 0
      txn(0, 4'd0, 32'd10, 32'd20, acc, res, z, lat, rv, ra, rb);
      chk("add_accept", acc, 1'b1);
      chk("add_lat",    lat, 2);
      chk("add_rv",     rv,  2'b01);
      chk("add_res",    res, 32'd30);
      chk("add_zero",   z,   1'b0);

      // SUB zero flag, requester 1
      txn(1, 4'd1, 32'd30, 32'd30, acc, res, z, lat, rv, ra, rb);
      chk("sub0_rv",   rv,  2'b10);
      chk("sub0_res",  res, 32'd0);
      chk("sub0_zero", z,   1'b1);
      txn(1, 4'd1, 32'd30, 32'd20, acc, res, z, lat, rv, ra, rb);
      chk("sub1_res",  res, 32'd10);
      chk("sub1_zero", z,   1'b0);

      // Hold stability: operands scrambled after accept inside txn
      txn(0, 4'd5, 32'd10, 32'd20, acc, res, z, lat, rv, ra, rb);
      chk("slt_res",  res, 32'd1);
      chk("slt_hold_a", ra, 32'd10);
      chk("slt_hold_b", rb, 32'd20);

      // Contention after reset
      pulse_reset();
      set_req(0, 4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F);
      set_req(1, 4'd6, 32'd8, 32'd2);
      bus.rsp_ready = 2'b11;
      bus.req_valid = 2'b11;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if ((bus.req_ready & bus.req_valid) != 2'b00) begin
            g_q.push_back(bus.req_ready[1] ? 1 : 0);
            c_q.push_back(i);
         end
         if (bus.rsp_valid != 2'b00) r_q.push_back(bus.rsp_result);
      end
      @(posedge clk); #1 bus.req_valid = 2'b00;
      wait_idle();
      while (g_q.size() < 4) g_q.push_back(-1);
      while (c_q.size() < 4) c_q.push_back(-100);
      while (r_q.size() < 2) r_q.push_back(32'hDEAD_BEEF);
      for (int k = 0; k < 4; k++) chk($sformatf("cont_grant%0d", k), g_q[k], k % 2);
      for (int k = 1; k < 4; k++) chk($sformatf("cont_gap%0d", k), c_q[k] - c_q[k-1], 3);
      chk("cont_res0", r_q[0], 32'hFFFFFFFF);
      chk("cont_res1", r_q[1], 32'd32);

      // Backpressure on requester 0 with requester 1 waiting
      @(posedge clk); #1;
      bus.rsp_ready = 2'b10;
      set_req(0, 4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F);
      bus.req_valid = 2'b01;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready[0]) begin acc = 1; break; end
      end
      chk("bp_accept", acc, 1'b1);
      @(posedge clk); #1;
      set_req(1, 4'd0, 32'd1, 32'd2);
      bus.req_valid = 2'b10;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid[0]) break;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_rv",     bus.rsp_valid,  2'b01);
         chk("bp_res",    bus.rsp_result, 32'd0);
         chk("bp_zero",   bus.rsp_zero,   1'b1);
         chk("bp_rready", bus.req_ready,  2'b00);
         chk("bp_busy",   busy,           1'b1);
         @(negedge clk);
      end
      @(posedge clk); #1 bus.rsp_ready = 2'b11;
      @(negedge clk);
      chk("bp_still_rv", bus.rsp_valid, 2'b01);
      @(negedge clk);
      chk("bp_idle_busy",   busy,          1'b0);
      chk("bp_idle_rready", bus.req_ready, 2'b10);
      @(posedge clk); #1 bus.req_valid = 2'b00;
      wait_idle();

      // Reset mid-operation
      @(posedge clk); #1;
      set_req(0, 4'd7, 32'd32, 32'd2);
      bus.req_valid = 2'b01;
      @(negedge clk);
      chk("rmid_rready", bus.req_ready, 2'b01);
      @(posedge clk); #1 bus.req_valid = 2'b00;
      #1 rst_n = 0;
      #1;
      chk("rmid_busy",   busy,           1'b0);
      chk("rmid_alu_a",  bus.alu_a,      32'd0);
      chk("rmid_alu_b",  bus.alu_b,      32'd0);
      chk("rmid_alu_op", bus.alu_op,     4'd0);
      chk("rmid_rv",     bus.rsp_valid,  2'b00);
      chk("rmid_res",    bus.rsp_result, 32'd0);
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rmid_no_rsp", bus.rsp_valid, 2'b00);
      end
      @(posedge clk); #1;
      set_req(0, 4'd3, 32'h1, 32'h2);
      set_req(1, 4'd3, 32'h4, 32'h8);
      bus.req_valid = 2'b11;
      @(negedge clk);
      chk("rmid_first_grant", bus.req_ready, 2'b01);
      @(posedge clk); #1 bus.req_valid = 2'b00;
      wait_idle();

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         bus.req_valid[0] = ($urandom_range(0, 9) < 6);
         bus.req_valid[1] = ($urandom_range(0, 9) < 6);
         bus.rsp_ready[0] = ($urandom_range(0, 3) != 0);
         bus.rsp_ready[1] = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < 2; r++) begin
            if ($urandom_range(0, 1) == 0)
               set_req(r, 4'($urandom_range(0, 15)), $urandom, $urandom);
            else
               set_req(r, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 40)),
                       32'($urandom_range(0, 40)));
         end
         if ($urandom_range(0, 599) == 0) begin
            #1 rst_n = 0;
            @(posedge clk); #1 rst_n = 1;
         end
      end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
